// File: rtl/mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe -- MEM/WB pipeline register with a one-entry skid buffer.
//
// The stage holds up to two entries: a main (head) register that drives the
// outputs and a skid register that catches one extra entry when the WB side
// stalls. o_ready and o_valid are registered and derived from the FSM state.
//
// FSM states: EMPTY (no entry), FULL (main only), SKID (main and skid).
//
// Optional feature: define MEM_WB_RETIRE_CNT_EN to build a 32-bit retire
// counter. It counts downstream transfers, wraps, and is cleared only by
// reset. Without the macro, o_retire_count is tied to 0.
//
// Ports:
//   i_clock          clock, rising edge
//   i_reset          synchronous active-high reset (overrides everything)
//   i_flush          synchronous flush: drops all held and incoming entries
//   i_valid/o_ready  upstream (MEM) handshake
//   i_dataread       memory read data
//   i_address        ALU result / memory address
//   i_rd_rt          destination register index
//   i_wb             write-back control: bit 1 RegWrite, bit 0 MemtoReg
//   o_valid/i_ready  downstream (WB) handshake
//   o_dataread, o_address, o_rd_rt, o_wb   head-entry fields
//   o_wb_data        o_dataread if o_wb[0] else o_address
//   o_retire_count   downstream transfer count (0 without the macro)
//
// WB_WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module mem_wb_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WB_WIDTH       = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_WIDTH-1:0]     i_dataread,
    input  logic [DATA_WIDTH-1:0]     i_address,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_rt,
    input  logic [WB_WIDTH-1:0]       i_wb,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_WIDTH-1:0]     o_dataread,
    output logic [DATA_WIDTH-1:0]     o_address,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_rt,
    output logic [WB_WIDTH-1:0]       o_wb,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic [31:0]               o_retire_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t state_q;
    logic   valid_q;
    logic   ready_q;

    logic [DATA_WIDTH-1:0]     main_data_q, main_addr_q;
    logic [REG_ADDR_WIDTH-1:0] main_rd_q;
    logic [WB_WIDTH-1:0]       main_wb_q;

    logic [DATA_WIDTH-1:0]     skid_data_q, skid_addr_q;
    logic [REG_ADDR_WIDTH-1:0] skid_rd_q;
    logic [WB_WIDTH-1:0]       skid_wb_q;

    // Write-back control as it will be stored: register 0 is hardwired, so a
    // write to it is suppressed at capture time instead of in the WB stage.
    logic [WB_WIDTH-1:0] cap_wb_d;

    always_comb begin
        cap_wb_d = i_wb;
        if (i_rd_rt == '0) begin
            cap_wb_d[1] = 1'b0;
        end
    end

    logic in_xfer;
    logic out_xfer;

    // o_ready is only ever high in EMPTY/FULL, so in_xfer never fires in SKID.
    assign in_xfer  = i_valid && ready_q;
    assign out_xfer = valid_q && i_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            main_data_q <= '0;
            main_addr_q <= '0;
            main_rd_q   <= '0;
            main_wb_q   <= '0;
            skid_data_q <= '0;
            skid_addr_q <= '0;
            skid_rd_q   <= '0;
            skid_wb_q   <= '0;
        end else if (i_flush) begin
            // Entries are dropped by state alone; data registers keep their
            // contents so the outputs stay stable while invalid.
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_q     <= ST_FULL;
                        valid_q     <= 1'b1;
                        ready_q     <= 1'b1;
                        main_data_q <= i_dataread;
                        main_addr_q <= i_address;
                        main_rd_q   <= i_rd_rt;
                        main_wb_q   <= cap_wb_d;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_data_q <= i_dataread;
                        main_addr_q <= i_address;
                        main_rd_q   <= i_rd_rt;
                        main_wb_q   <= cap_wb_d;
                    end else if (in_xfer) begin
                        state_q     <= ST_SKID;
                        valid_q     <= 1'b1;
                        ready_q     <= 1'b0;
                        skid_data_q <= i_dataread;
                        skid_addr_q <= i_address;
                        skid_rd_q   <= i_rd_rt;
                        skid_wb_q   <= cap_wb_d;
                    end else if (out_xfer) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_q     <= ST_FULL;
                        valid_q     <= 1'b1;
                        ready_q     <= 1'b1;
                        main_data_q <= skid_data_q;
                        main_addr_q <= skid_addr_q;
                        main_rd_q   <= skid_rd_q;
                        main_wb_q   <= skid_wb_q;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_valid    = valid_q;
    assign o_ready    = ready_q;
    assign o_dataread = main_data_q;
    assign o_address  = main_addr_q;
    assign o_rd_rt    = main_rd_q;
    assign o_wb       = main_wb_q;
    assign o_wb_data  = main_wb_q[0] ? main_data_q : main_addr_q;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    // A transfer in a flush cycle still completes, so flush does not gate it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            retire_cnt_q <= '0;
        end else if (out_xfer) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign o_retire_count = retire_cnt_q;
`else
    assign o_retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe -- scoreboard bench for mem_wb_pipe.
//
// The reference model is an ordered queue of expected entries with a capacity
// of two: accepted entries are pushed on the rising edge, flush/reset empties
// it, and a monitor on the falling edge checks handshake flags, head fields
// and the retire count, popping on each downstream transfer.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] i_dataread = '0;
    logic [DW-1:0] i_address = '0;
    logic [RW-1:0] i_rd_rt = '0;
    logic [WW-1:0] i_wb = '0;
    logic          o_ready, o_valid;
    logic [DW-1:0] o_dataread, o_address, o_wb_data;
    logic [RW-1:0] o_rd_rt;
    logic [WW-1:0] o_wb;
    logic [31:0]   o_retire_count;

    mem_wb_pipe #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .WB_WIDTH(WW)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_dataread(i_dataread), .i_address(i_address),
        .i_rd_rt(i_rd_rt), .i_wb(i_wb),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_dataread(o_dataread), .o_address(o_address),
        .o_rd_rt(o_rd_rt), .o_wb(o_wb), .o_wb_data(o_wb_data),
        .o_retire_count(o_retire_count)
    );

    // First rising edge at t=5 so the first monitor sample follows a reset edge.
    always begin
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] addr;
        logic [RW-1:0] rd;
        logic [WW-1:0] wb;
        logic [DW-1:0] wb_data;
    } entry_t;

    entry_t      sb[$];
    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] cnt_model = 32'd0;
    bit          expect_zero = 1'b0;

    function automatic entry_t mk(logic [DW-1:0] d, logic [DW-1:0] a,
                                  logic [RW-1:0] r, logic [WW-1:0] w);
        entry_t e;
        e.data = d;
        e.addr = a;
        e.rd   = r;
        e.wb   = w;
        if (r == 0) e.wb[1] = 1'b0;
        e.wb_data = e.wb[0] ? d : a;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Recorder: update the model queue with what happens at this edge.
    always @(posedge clk) begin
        if (i_reset || i_flush) begin
            sb.delete();
        end else if (i_valid && o_ready) begin
            sb.push_back(mk(i_dataread, i_address, i_rd_rt, i_wb));
        end
    end

    // Monitor: compare DUT against the model, then retire the head if the
    // WB side takes it at the coming edge.
    always @(negedge clk) begin
        chk("o_valid", 32'(o_valid), 32'(sb.size() > 0));
        chk("o_ready", 32'(o_ready), 32'(sb.size() < 2));
        if (expect_zero) begin
            chk("rst_dataread", o_dataread, 32'd0);
            chk("rst_address", o_address, 32'd0);
            chk("rst_rd_rt", 32'(o_rd_rt), 32'd0);
            chk("rst_wb", 32'(o_wb), 32'd0);
            chk("rst_wb_data", o_wb_data, 32'd0);
            expect_zero = 1'b0;
        end
        if (o_valid && sb.size() > 0) begin
            chk("head_dataread", o_dataread, sb[0].data);
            chk("head_address", o_address, sb[0].addr);
            chk("head_rd_rt", 32'(o_rd_rt), 32'(sb[0].rd));
            chk("head_wb", 32'(o_wb), 32'(sb[0].wb));
            chk("head_wb_data", o_wb_data, sb[0].wb_data);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("retire_count", o_retire_count, cnt_model);
`else
        chk("retire_count", o_retire_count, 32'd0);
`endif
        if (sb.size() > 0 && i_ready && !i_reset) begin
            void'(sb.pop_front());
            cnt_model = cnt_model + 32'd1;
        end
        if (i_reset) begin
            cnt_model   = 32'd0;
            expect_zero = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted (bounded).
    task automatic send(logic [DW-1:0] d, logic [DW-1:0] a,
                        logic [RW-1:0] r, logic [WW-1:0] w);
        bit acc = 1'b0;
        i_dataread = d;
        i_address  = a;
        i_rd_rt    = r;
        i_wb       = w;
        i_valid    = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = o_ready;
            step();
        end
        i_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_mis++;
            $display("FAIL send_timeout: got not-accepted, want accepted (t=%0t)", $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles.
        step();
        step();
        i_reset = 1'b0;
        i_ready = 1'b1;
        step();

        // Single entry through an empty stage.
        send(32'hAAAA0000, 32'h10, 5'd3, 2'b11);
        @(negedge clk);
        chk("first_valid", 32'(o_valid), 32'd1);
        chk("first_wb_data", o_wb_data, 32'hAAAA0000);
        chk("first_wb", 32'(o_wb), 32'd3);
        step();
        step();

        // Stall: A, B accepted; C waits until the WB side releases.
        i_ready = 1'b0;
        send(32'h0A, 32'hA0, 5'd1, 2'b01);
        send(32'h0B, 32'hB0, 5'd2, 2'b10);
        @(negedge clk);
        chk("skid_ready", 32'(o_ready), 32'd0);
        fork
            begin
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("drain_no_gap", 32'(o_valid), 32'd1);
                end
            end
            send(32'h0C, 32'hC0, 5'd4, 2'b11);
        join
        repeat (4) step();

        // Write to register 0 is suppressed at capture.
        send(32'h1234, 32'h55, 5'd0, 2'b10);
        @(negedge clk);
        chk("r0_wb", 32'(o_wb), 32'd0);
        chk("r0_wb_data", o_wb_data, 32'h55);
        repeat (3) step();

        // Flush while in SKID with a new entry offered.
        i_ready = 1'b0;
        send(32'h11, 32'h110, 5'd5, 2'b11);
        send(32'h22, 32'h220, 5'd6, 2'b11);
        i_dataread = 32'h33;
        i_address  = 32'h330;
        i_rd_rt    = 5'd7;
        i_valid    = 1'b1;
        i_flush    = 1'b1;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        repeat (4) step();

        // Reset + flush while in SKID.
        i_ready = 1'b0;
        send(32'h44, 32'h440, 5'd8, 2'b01);
        send(32'h66, 32'h660, 5'd9, 2'b11);
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_reset = 1'b1;
        step();
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_skid_ready", 32'(o_ready), 32'd1);
        chk("rst_skid_count", o_retire_count, 32'd0);
        i_ready = 1'b1;
        repeat (2) step();

`ifdef MEM_WB_RETIRE_CNT_EN
        // Counter wrap: start near the top, then four transfers.
        i_ready = 1'b0;
        force dut.retire_cnt_q = 32'hFFFFFFFC;
        cnt_model = 32'hFFFFFFFC;
        #1 release dut.retire_cnt_q;
        step();
        i_ready = 1'b1;
        send(32'h1, 32'h1, 5'd1, 2'b11);
        send(32'h2, 32'h2, 5'd2, 2'b11);
        step();
        @(negedge clk);
        chk("cnt_pre_wrap", o_retire_count, 32'hFFFFFFFE);
        send(32'h3, 32'h3, 5'd3, 2'b11);
        send(32'h4, 32'h4, 5'd4, 2'b11);
        step();
        @(negedge clk);
        chk("cnt_wrapped", o_retire_count, 32'h0);
        step();
`endif

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 600; c++) begin
            i_valid    = ($urandom_range(0, 99) < 60);
            i_ready    = ($urandom_range(0, 99) < 55);
            i_flush    = ($urandom_range(0, 99) < 3);
            i_dataread = $urandom;
            i_address  = $urandom;
            i_rd_rt    = RW'($urandom_range(0, 7));
            i_wb       = WW'($urandom);
            step();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
